serial_subtractor: RTL and testbench

- Parametrised, digit-serial N-bit subtractor; generalises the half-subtractor to multi-bit operands.
- Computes diff = a − b, DIGIT bits per clock, LSB digit first, keeping a registered borrow between digits.
- Sequenced by a start/busy/done handshake.
- Reports the unsigned borrow and the two's-complement overflow, for use by arithmetic datapaths that trade latency for area.

---
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b, DIGIT bits per clock, LSB digit first.
// Reports unsigned borrow and two's-complement overflow via a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             bin_q, bin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d, ovf_q, ovf_d;
  logic [DIGIT:0]   dig;

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    dig      = {1'b0, a_sr_q[DIGIT-1:0]} - {1'b0, b_sr_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, bin_q};
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_d[cnt_q*DIGIT +: DIGIT] = dig[DIGIT-1:0];
        bin_d  = dig[DIGIT];
        a_sr_d = a_sr_q >> DIGIT;
        b_sr_d = b_sr_q >> DIGIT;
        cnt_d  = cnt_q + 1'b1;
        // Results are published only on the last digit; earlier digits stay internal.
        if (cnt_q == CW'(N - 1)) begin
          diff_d   = res_d;
          borrow_d = dig[DIGIT];
          ovf_d    = (a_msb_q ^ b_msb_q) & (res_d[WIDTH-1] ^ a_msb_q);
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboarded bench for serial_subtractor at WIDTH/DIGIT = 8/1, 8/4 and 2/1.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       s0 = 0, s1 = 0, s2 = 0;
  logic [7:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [1:0] a2 = 0, b2 = 0;
  logic       busy0, done0, brw0, ovf0, busy1, done1, brw1, ovf1, busy2, done2, brw2, ovf2;
  logic [7:0] diff0, diff1;
  logic [1:0] diff2;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst_n(rst_n), .start(s0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .diff(diff0), .borrow(brw0), .ovf(ovf0));
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u1 (.clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(brw1), .ovf(ovf1));
  serial_subtractor #(.WIDTH(2), .DIGIT(1)) u2 (.clk(clk), .rst_n(rst_n), .start(s2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow(brw2), .ovf(ovf2));

  int n_chk = 0, n_fail = 0;
  logic [9:0] q0[$], q1[$], q2[$];
  logic [9:0] held2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // {ovf, borrow, diff} for a w-bit subtraction
  function automatic logic [9:0] ref_sub(input int w, input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] m, x, y, d;
    logic       o;
    m = 8'hFF >> (8 - w);
    x = av & m;
    y = bv & m;
    d = (x - y) & m;
    o = (x[w-1] != y[w-1]) && (d[w-1] != x[w-1]);
    return {o, (x < y), d};
  endfunction

  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) chk("u0 spurious done", 32'd1, 32'd0);
      else chk("u0 result", {22'd0, ovf0, brw0, diff0}, {22'd0, q0.pop_front()});
    end
    if (done1) begin
      if (q1.size() == 0) chk("u1 spurious done", 32'd1, 32'd0);
      else chk("u1 result", {22'd0, ovf1, brw1, diff1}, {22'd0, q1.pop_front()});
    end
    if (done2) begin
      if (q2.size() == 0) chk("u2 spurious done", 32'd1, 32'd0);
      else chk("u2 result", {22'd0, ovf2, brw2, 6'd0, diff2}, {22'd0, q2.pop_front()});
    end
  end

  // Outputs of the 2-bit instance must only move on a done cycle.
  always @(negedge clk) begin
    if (!rst_n) held2 <= '0;
    else if (done2) held2 <= {ovf2, brw2, 6'd0, diff2};
    else chk("u2 hold", {22'd0, ovf2, brw2, 6'd0, diff2}, {22'd0, held2});
  end

  // Called just after a rising edge; returns just after the start-sampling edge.
  task automatic launch(input int sel, input logic [7:0] av, input logic [7:0] bv);
    case (sel)
      0: begin s0 = 1; a0 = av; b0 = bv; q0.push_back(ref_sub(8, av, bv)); end
      1: begin s1 = 1; a1 = av; b1 = bv; q1.push_back(ref_sub(8, av, bv)); end
      default: begin s2 = 1; a2 = av[1:0]; b2 = bv[1:0]; q2.push_back(ref_sub(2, av, bv)); end
    endcase
    @(posedge clk); #1;
    s0 = 0; s1 = 0; s2 = 0;
  endtask

  task automatic wait_done(input int sel);
    logic d;
    for (int i = 0; i < 20; i++) begin
      d = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
      if (d) return;
      @(posedge clk); #1;
    end
    chk("done timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1 rst_n = 0;
    #3;
    chk("reset u0", {27'd0, busy0, done0, brw0, ovf0, |diff0}, 32'd0);
    chk("reset u2", {27'd0, busy2, done2, brw2, ovf2, |diff2}, 32'd0);
    #10 rst_n = 1;
    @(posedge clk); #1;

    // 5 - 3 with cycle-exact handshake timing
    launch(0, 8'd5, 8'd3);
    chk("busy at edge0", {31'd0, busy0}, 32'd1);
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); #1;
      chk("busy run", {31'd0, busy0}, (j < 8) ? 32'd1 : 32'd0);
      chk("done run", {31'd0, done0}, (j == 8) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    chk("done width", {31'd0, done0}, 32'd0);

    launch(0, 8'h00, 8'h01); wait_done(0); @(posedge clk); #1;
    launch(0, 8'h80, 8'h01); wait_done(0); @(posedge clk); #1;

    // 4-bit digits, back-to-back restart from DONE
    launch(1, 8'h3C, 8'hC3);
    @(posedge clk); #1;
    chk("u1 not done e1", {31'd0, done1}, 32'd0);
    @(posedge clk); #1;
    chk("u1 done e2", {31'd0, done1}, 32'd1);
    launch(1, 8'hAA, 8'hAA);
    chk("u1 restart busy", {31'd0, busy1}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("u1 done b2b", {31'd0, done1}, 32'd1);
    @(posedge clk); #1;

    // start mid-RUN is ignored
    launch(0, 8'h10, 8'h04);
    repeat (3) begin @(posedge clk); #1; end
    s0 = 1; a0 = 8'hFF; b0 = 8'h00;
    @(posedge clk); #1;
    s0 = 0;
    wait_done(0);
    repeat (12) begin @(posedge clk); #1; end

    // asynchronous reset mid-RUN
    launch(0, 8'h20, 8'h01);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 0;
    #1;
    chk("abort diff", {24'd0, diff0}, 32'd0);
    chk("abort flags", {29'd0, busy0, done0, brw0}, 32'd0);
    q0.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
    chk("post-reset idle", {30'd0, busy0, done0}, 32'd0);
    launch(0, 8'h20, 8'h01); wait_done(0); @(posedge clk); #1;

    // exhaustive 2-bit sweep
    for (int i = 0; i < 16; i++) begin
      launch(2, {6'd0, 2'(i >> 2)}, {6'd0, 2'(i)});
      wait_done(2);
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("q0 drained", q0.size(), 32'd0);
    chk("q1 drained", q1.size(), 32'd0);
    chk("q2 drained", q2.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
